qpmux_sel_ctrl: RTL and testbench

Sequencer that drives the IS0/IS1 select pins of the global-clock pad mux and changes clock source without glitches. On a source-change request it gates the downstream clock, drains, switches the select, waits for the new source to be alive and settled, then re-enables. It sits in the always-on control domain beside each QPMUX and replaces static select tie-offs.

---
 rtl/qpmux_sel_ctrl_pkg.sv | 32 +++
 rtl/qpmux_sel_ctrl_sync2.sv | 26 ++
 rtl/qpmux_sel_ctrl.sv | 163 ++++++++++++++++
 tb/tb_qpmux_sel_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/qpmux_sel_ctrl_pkg.sv
// Shared constants for the QPMUX select sequencer: source codes, FSM states,
// and the source -> {IS1,IS0} pad encoding.
package qpmux_sel_pkg;

  localparam logic [1:0] SRC_QCLKIN = 2'd0;
  localparam logic [1:0] SRC_GMUXIN = 2'd1;
  localparam logic [1:0] SRC_QHSCK  = 2'd2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_DRAIN  = 3'd1;
  localparam state_t ST_SWITCH = 3'd2;
  localparam state_t ST_SETTLE = 3'd3;
  localparam state_t ST_REVERT = 3'd4;
  localparam state_t ST_ENABLE = 3'd5;

  // Request code 3 is an alias for QHSCK; everything downstream sees 0/1/2.
  function automatic logic [1:0] src_canon(input logic [1:0] s);
    return (s == 2'd3) ? SRC_QHSCK : s;
  endfunction

  // {IS1,IS0}; 2'b11 is never produced.
  function automatic logic [1:0] src_to_is(input logic [1:0] s);
    case (s)
      SRC_QCLKIN: return 2'b00;
      SRC_GMUXIN: return 2'b01;
      default:    return 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/qpmux_sel_ctrl_sync2.sv
// Two-flop synchronizer bank for asynchronous level flags.
module qpmux_sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/qpmux_sel_ctrl.sv
// Glitch-free QPMUX source sequencer: gate, drain, switch select, wait for the
// new source to be alive and settled (or revert on timeout), then re-enable.
module qpmux_sel_ctrl
  import qpmux_sel_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic       QCK_i,
  input  logic       QRT_i,
  input  logic       REQ_VALID_i,
  input  logic [1:0] REQ_SRC_i,
  output logic       REQ_READY_o,
  input  logic [2:0] SRC_ALIVE_i,
  output logic       IS0_o,
  output logic       IS1_o,
  output logic       CLK_EN_o,
  output logic [1:0] CUR_SRC_o,
  output logic       DONE_o,
  output logic       ERR_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       is_q, is_d;
  logic             clk_en_q, clk_en_d;
  logic [1:0]       cur_q, cur_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [1:0]       old_q, old_d;
  logic             abort_q, abort_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [2:0]       alive_s;
  logic [3:0]       alive_x;
  logic             tgt_alive;
  logic [1:0]       req_src_c;

  qpmux_sync2 #(.W(3)) u_sync (
    .clk_i (QCK_i),
    .rst_i (QRT_i),
    .d_i   (SRC_ALIVE_i),
    .q_o   (alive_s)
  );

  // Pad to four entries so a 2-bit source code indexes cleanly.
  assign alive_x   = {1'b0, alive_s};
  assign tgt_alive = alive_x[tgt_q];
  assign req_src_c = src_canon(REQ_SRC_i);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_d     = is_q;
    clk_en_d = clk_en_q;
    cur_d    = cur_q;
    tgt_d    = tgt_q;
    old_d    = old_q;
    abort_d  = abort_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID_i) begin
          tgt_d   = req_src_c;
          old_d   = cur_q;
          abort_d = 1'b0;
          cnt_d   = '0;
          if (req_src_c == cur_q) begin
            state_d = ST_ENABLE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_DRAIN;
            clk_en_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = ST_SWITCH;
          is_d    = src_to_is(tgt_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SWITCH: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
      ST_SETTLE: begin
        // A live target on the last timeout cycle still wins over revert.
        if (cnt_q >= SETTLE_LAST && tgt_alive) begin
          state_d  = ST_ENABLE;
          clk_en_d = 1'b1;
          done_d   = 1'b1;
          cur_d    = tgt_q;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_REVERT;
          abort_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REVERT: begin
        state_d  = ST_ENABLE;
        is_d     = src_to_is(old_q);
        clk_en_d = 1'b1;
        done_d   = 1'b1;
        err_d    = abort_q;
      end
      ST_ENABLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        clk_en_d = 1'b1;
        is_d     = src_to_is(cur_q);
      end
    endcase
  end

  // Reset drops straight back to QCLKIN with the gate open; no drain.
  always_ff @(posedge QCK_i) begin
    if (QRT_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_q     <= src_to_is(SRC_QCLKIN);
      clk_en_q <= 1'b1;
      cur_q    <= SRC_QCLKIN;
      tgt_q    <= SRC_QCLKIN;
      old_q    <= SRC_QCLKIN;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_q     <= is_d;
      clk_en_q <= clk_en_d;
      cur_q    <= cur_d;
      tgt_q    <= tgt_d;
      old_q    <= old_d;
      abort_q  <= abort_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign REQ_READY_o = (state_q == ST_IDLE);
  assign IS0_o       = is_q[0];
  assign IS1_o       = is_q[1];
  assign CLK_EN_o    = clk_en_q;
  assign CUR_SRC_o   = cur_q;
  assign DONE_o      = done_q;
  assign ERR_o       = err_q;

endmodule

// File: tb/tb_qpmux_sel_ctrl.sv
// Bench for qpmux_sel_ctrl: directed and randomized source-change requests
// against a cycle-timeline model derived from the drain/settle/timeout rules.
module tb_qpmux_sel_ctrl;

  localparam int D     = 4;
  localparam int S     = 8;
  localparam int T     = 256;
  localparam int NEVER = 100000;

  logic       qck = 1'b0;
  logic       qrt;
  logic       req_valid;
  logic [1:0] req_src;
  logic       req_ready;
  logic [2:0] src_alive;
  logic       is0, is1, clk_en, done, err;
  logic [1:0] cur_src;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] cur_m   = 2'd0;

  qpmux_sel_ctrl #(
    .DRAIN_CYCLES   (D),
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .QCK_i       (qck),
    .QRT_i       (qrt),
    .REQ_VALID_i (req_valid),
    .REQ_SRC_i   (req_src),
    .REQ_READY_o (req_ready),
    .SRC_ALIVE_i (src_alive),
    .IS0_o       (is0),
    .IS1_o       (is1),
    .CLK_EN_o    (clk_en),
    .CUR_SRC_o   (cur_src),
    .DONE_o      (done),
    .ERR_o       (err)
  );

  always #5 qck = ~qck;

  function automatic logic [1:0] enc(input logic [1:0] s);
    case (s)
      2'd0:    return 2'b00;
      2'd1:    return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  task automatic check(input string tag, input int k, input logic [1:0] obs, input logic [1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: got %0d expected %0d", tag, k, obs, exp);
    end
  endtask

  // rise: cycle (relative to accept) at which the target alive flag goes high;
  // negative means already high, NEVER means it stays low.
  task automatic run_req(input logic [1:0] src, input int rise);
    logic [1:0] tgt, old, fin, exp_is;
    int         done_c, x;
    bit         err_e, same, exp_en;
    tgt  = (src == 2'd3) ? 2'd2 : src;
    old  = cur_m;
    same = (tgt == old);
    if (same) begin
      done_c = 1;
      err_e  = 1'b0;
    end else begin
      x = (D + 2) + S - 1;
      if (rise >= 0 && rise + 2 > x) x = rise + 2;
      if (x <= (D + 2) + T - 1) begin
        done_c = x + 1;
        err_e  = 1'b0;
      end else begin
        done_c = (D + 2) + T + 1;
        err_e  = 1'b1;
      end
    end
    fin = err_e ? old : tgt;
    for (int k = -3; k <= done_c + 1; k++) begin
      req_valid = (k == 0) || (k > 0 && k <= done_c && $urandom_range(0, 1) == 1);
      req_src   = (k == 0) ? src : 2'($urandom_range(0, 3));
      src_alive = 3'($urandom);
      src_alive[tgt] = (rise < 0) || (k >= rise);
      @(negedge qck);
      if (k >= 0) begin
        exp_en = same ? 1'b1 : !(k >= 1 && k < done_c);
        if (same || k < D + 1)        exp_is = enc(old);
        else if (err_e && k >= done_c) exp_is = enc(old);
        else                           exp_is = enc(tgt);
        check("clk_en", k, {1'b0, clk_en}, {1'b0, exp_en});
        check("is", k, {is1, is0}, exp_is);
        check("done", k, {1'b0, done}, {1'b0, k == done_c});
        check("err", k, {1'b0, err}, {1'b0, k == done_c && err_e});
        check("ready", k, {1'b0, req_ready}, {1'b0, k == 0 || k > done_c});
        check("cur_src", k, cur_src, (k < done_c) ? old : fin);
      end
      @(posedge qck); #1;
    end
    req_valid = 1'b0;
    cur_m = fin;
  endtask

  initial begin
    qrt       = 1'b1;
    req_valid = 1'b0;
    req_src   = 2'd0;
    src_alive = 3'b000;
    repeat (2) @(posedge qck);
    #1 qrt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge qck);
      check("rst_is", k, {is1, is0}, 2'b00);
      check("rst_clk_en", k, {1'b0, clk_en}, 2'b01);
      check("rst_cur", k, cur_src, 2'd0);
      check("rst_ready", k, {1'b0, req_ready}, 2'b01);
      check("rst_done", k, {done, err}, 2'b00);
      @(posedge qck); #1;
    end

    run_req(2'd0, -1);     // same source, no gating
    run_req(2'd3, NEVER);  // QHSCK never alive: revert + ERR
    run_req(2'd1, -1);     // nominal switch to GMUXIN
    run_req(2'd1, NEVER);  // same source again
    run_req(2'd2, 20);     // target comes alive late
    run_req(2'd0, 259);    // alive just in time on the last settle cycle
    run_req(2'd1, 260);    // alive one cycle too late

    // Reset mid-switch: request from QCLKIN, reset asserted at cycle 8.
    run_req(2'd0, NEVER);
    for (int k = 0; k <= 11; k++) begin
      req_valid = (k == 0);
      req_src   = 2'd1;
      src_alive = 3'b111;
      qrt       = (k == 8);
      @(negedge qck);
      if (k == 9) begin
        check("qrt_is", k, {is1, is0}, 2'b00);
        check("qrt_clk_en", k, {1'b0, clk_en}, 2'b01);
        check("qrt_ready", k, {1'b0, req_ready}, 2'b01);
        check("qrt_cur", k, cur_src, 2'd0);
      end
      if (k >= 9) check("qrt_done", k, {done, err}, 2'b00);
      @(posedge qck); #1;
    end
    qrt   = 1'b0;
    cur_m = 2'd0;

    for (int i = 0; i < 10; i++) begin
      int r;
      case ($urandom_range(0, 3))
        0:       r = -1;
        1:       r = int'($urandom_range(0, 40));
        2:       r = NEVER;
        default: r = int'($urandom_range(250, 263));
      endcase
      run_req(2'($urandom_range(0, 3)), r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
